// File: rtl/config_tx.sv
// Host-side configuration transmitter: sends a 3-word frame on config_req/config_data and
// confirms it by watching the synchronised cpol/cpha/spi_width readback, retrying on timeout.
module config_tx #(
   parameter int unsigned DIV       = 4,
   parameter int unsigned TIMEOUT   = 64,
   parameter int unsigned MAX_RETRY = 2,
   parameter logic [5:0]  SYNC      = 6'h2A
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic       cfg_cpol,
   input  logic       cfg_cpha,
   input  logic [3:0] cfg_spi_width,
   output logic       config_req,
   output logic [5:0] config_data,
   input  logic       cpol_in,
   input  logic       cpha_in,
   input  logic [3:0] spi_width_in,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned DivW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned WaitW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [DivW-1:0]   DivLast  = DivW'(DIV - 1);
   localparam logic [WaitW-1:0]  WaitLast = WaitW'(TIMEOUT - 1);
   localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

   typedef enum logic [2:0] {StIdle, StSend, StWait, StGap, StDone, StErr} state_e;

   state_e            state_q;
   logic [5:0]        w1_q;
   logic [5:0]        w2;
   logic [DivW-1:0]   div_q;
   logic [1:0]        word_q;
   logic [WaitW-1:0]  wait_q;
   logic [RetryW-1:0] retry_q;
   logic [5:0]        rb_meta_q;
   logic [5:0]        rb_sync_q;
   logic              rb_match;

   always_comb begin
      w2       = SYNC ^ w1_q;
      rb_match = (rb_sync_q == w1_q);
   end

   assign cfg_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         w1_q        <= 6'h00;
         div_q       <= '0;
         word_q      <= 2'd0;
         wait_q      <= '0;
         retry_q     <= '0;
         rb_meta_q   <= 6'h00;
         rb_sync_q   <= 6'h00;
         config_req  <= 1'b0;
         config_data <= 6'h00;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         rb_meta_q <= {cpol_in, cpha_in, spi_width_in};
         rb_sync_q <= rb_meta_q;
         done      <= 1'b0;
         err       <= 1'b0;

         case (state_q)
            StIdle: begin
               if (cfg_valid) begin
                  w1_q        <= {cfg_cpol, cfg_cpha, cfg_spi_width};
                  retry_q     <= '0;
                  div_q       <= '0;
                  word_q      <= 2'd0;
                  config_req  <= 1'b1;
                  config_data <= SYNC;
                  state_q     <= StSend;
               end
            end
            StSend: begin
               if (div_q == DivLast) begin
                  div_q <= '0;
                  if (word_q == 2'd2) begin
                     config_req  <= 1'b0;
                     config_data <= 6'h00;
                     wait_q      <= '0;
                     state_q     <= StWait;
                  end else begin
                     word_q      <= word_q + 2'd1;
                     config_data <= (word_q == 2'd0) ? w1_q : w2;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            StWait: begin
               // A match on the last allowed cycle still wins over the timeout.
               if (rb_match) begin
                  done    <= 1'b1;
                  state_q <= StDone;
               end else if (wait_q == WaitLast) begin
                  if (retry_q < RetryMax) begin
                     retry_q <= retry_q + 1'b1;
                     state_q <= StGap;
                  end else begin
                     err     <= 1'b1;
                     state_q <= StErr;
                  end
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            StGap: begin
               div_q       <= '0;
               word_q      <= 2'd0;
               config_req  <= 1'b1;
               config_data <= SYNC;
               state_q     <= StSend;
            end
            StDone:  state_q <= StIdle;
            StErr:   state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_config_tx.sv
// Randomised and directed bench for config_tx; expected bus traces come from a
// per-attempt timeline model built from the frame/retry rules.
module tb_config_tx;

   localparam int unsigned DIV  = 4;
   localparam int unsigned TO   = 8;
   localparam int unsigned MR   = 2;
   localparam logic [5:0]  SYNC = 6'h2A;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_valid;
   logic       cfg_ready;
   logic       cfg_cpol;
   logic       cfg_cpha;
   logic [3:0] cfg_spi_width;
   logic       config_req;
   logic [5:0] config_data;
   logic [5:0] rb;
   logic       busy;
   logic       done;
   logic       err;

   int n_assert = 0;
   int n_fail   = 0;

   // Observation word: {ready, busy, req, data[5:0], done, err}
   logic [10:0] exp_q[$];
   logic [10:0] got_q[$];

   config_tx #(.DIV(DIV), .TIMEOUT(TO), .MAX_RETRY(MR), .SYNC(SYNC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_cpol     (cfg_cpol),
      .cfg_cpha     (cfg_cpha),
      .cfg_spi_width(cfg_spi_width),
      .config_req   (config_req),
      .config_data  (config_data),
      .cpol_in      (rb[5]),
      .cpha_in      (rb[4]),
      .spi_width_in (rb[3:0]),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] obs();
      return {cfg_ready, busy, config_req, config_data, done, err};
   endfunction

   // Expected timeline: samples are taken 1 time unit after each edge, index 0 = accept edge.
   task automatic model(input logic [5:0] w1, input logic [5:0] rb0, input int chg_at,
                        input logic [5:0] rb1);
      logic [5:0] words[3];
      logic [5:0] seen;
      int         t;
      bit         ok;
      words[0] = SYNC;
      words[1] = w1;
      words[2] = SYNC ^ w1;
      t  = 0;
      ok = 1'b0;
      exp_q.delete();
      for (int a = 0; a <= int'(MR); a++) begin
         for (int k = 0; k < 3 * int'(DIV); k++)
            exp_q.push_back({2'b01, 1'b1, words[k / int'(DIV)], 2'b00});
         t += 3 * int'(DIV);
         for (int k = 0; k < int'(TO); k++) begin
            // two synchroniser stages between the pin change and the compare
            seen = (t >= chg_at + 2) ? rb1 : rb0;
            exp_q.push_back({2'b01, 1'b0, 6'h00, 2'b00});
            t++;
            if (seen == w1) begin
               ok = 1'b1;
               break;
            end
         end
         if (ok) begin
            exp_q.push_back({2'b01, 1'b0, 6'h00, 2'b10});
            break;
         end
         if (a < int'(MR)) begin
            exp_q.push_back({2'b01, 1'b0, 6'h00, 2'b00});
            t++;
         end else begin
            exp_q.push_back({2'b01, 1'b0, 6'h00, 2'b01});
         end
      end
      exp_q.push_back({2'b10, 1'b0, 6'h00, 2'b00});
   endtask

   function automatic int count_rise(input int pos);
      int   n;
      logic prev;
      n    = 0;
      prev = 1'b0;
      foreach (got_q[i]) begin
         if (got_q[i][pos] && !prev) n++;
         prev = got_q[i][pos];
      end
      return n;
   endfunction

   function automatic int first_set(input int pos);
      foreach (got_q[i]) if (got_q[i][pos]) return i;
      return -1;
   endfunction

   task automatic do_op(input string tag, input logic [5:0] w1, input int chg_at,
                        input logic [5:0] rb1, input bit hold, input logic [5:0] post_w1);
      int j;
      model(w1, rb, chg_at, rb1);
      {cfg_cpol, cfg_cpha, cfg_spi_width} = w1;
      cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      if (hold) {cfg_cpol, cfg_cpha, cfg_spi_width} = post_w1;
      else cfg_valid = 1'b0;
      got_q.delete();
      j = 0;
      while (1) begin
         got_q.push_back(obs());
         if (j == chg_at) rb = rb1;
         if (cfg_ready || j >= 300) break;
         @(posedge clk);
         #1;
         j++;
      end
      check({tag, " trace_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s cyc%0d", tag, i + 1), got_q[i], exp_q[i]);
   endtask

   task automatic settle(input logic [5:0] v);
      rb = v;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0] w;
      logic [5:0] r0;
      bit         quiet;

      rst_n         = 1'b0;
      cfg_valid     = 1'b0;
      {cfg_cpol, cfg_cpha, cfg_spi_width} = 6'h00;
      rb            = 6'h00;
      #12;
      check("rst_req", config_req, 0);
      check("rst_data", config_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done_err", {done, err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ready", cfg_ready, 1);

      // Readback already matching: done at cycle 3*DIV+2, ready one cycle later
      settle(6'h28);
      do_op("match", 6'h28, 1000, 6'h28, 1'b0, 6'h00);
      check("match_done_cyc", first_set(1) + 1, 3 * DIV + 2);
      check("match_ready_cyc", first_set(10) + 1, 3 * DIV + 3);
      check("match_w1_bus", got_q[DIV][7:2], 6'h28);

      // Readback stuck at zero: all attempts time out
      settle(6'h00);
      do_op("stuck", 6'h28, 1000, 6'h00, 1'b0, 6'h00);
      check("stuck_frames", count_rise(8), MR + 1);
      check("stuck_err", count_rise(0), 1);
      check("stuck_done", count_rise(1), 0);

      // Wrong first, corrected during the second frame
      settle(6'h00);
      do_op("retry", 6'h1C, 25, 6'h1C, 1'b0, 6'h00);
      check("retry_frames", count_rise(8), 2);
      check("retry_done", count_rise(1), 1);
      check("retry_err", count_rise(0), 0);

      // W1=3F, match appears on the final allowed wait cycle
      settle(6'h00);
      do_op("late", 6'h3F, 3 * DIV + TO - 3, 6'h3F, 1'b0, 6'h00);
      check("late_w2", got_q[2 * DIV][7:2], 6'h15);
      check("late_frames", count_rise(8), 1);
      check("late_done", count_rise(1), 1);

      // cfg_valid held high; inputs change mid-operation and are latched only on the next accept
      settle(6'h11);
      do_op("hold1", 6'h11, 1000, 6'h11, 1'b1, 6'h26);
      check("hold1_frames", count_rise(8), 1);
      do_op("hold2", 6'h26, 1000, 6'h11, 1'b0, 6'h00);
      check("hold2_first_w1", got_q[DIV][7:2], 6'h26);

      // Random configurations and readback behaviour
      for (int n = 0; n < 8; n++) begin
         w  = 6'($urandom);
         r0 = ($urandom_range(0, 2) == 0) ? w : 6'($urandom);
         settle(r0);
         do_op($sformatf("rnd%0d", n), w, int'($urandom_range(0, 70)), w, 1'b0, 6'h00);
      end

      // Asynchronous reset while W1 is on the bus
      settle(6'h0A);
      {cfg_cpol, cfg_cpha, cfg_spi_width} = 6'h0A;
      cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      repeat (DIV + 1) @(posedge clk);
      #1;
      check("arst_pre_w1", config_data, 6'h0A);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_req", config_req, 0);
      check("arst_data", config_data, 0);
      check("arst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (config_req || done || err || !cfg_ready) quiet = 1'b0;
      end
      check("arst_idle_quiet", quiet, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
